// File: rtl/wishbone_pkg.sv
// Shared types and width constants for the Wishbone arbiter.
package wishbone_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_GRANTED = 2'd1,
      ST_ABORT   = 2'd2
   } state_e;

   // Largest supported outstanding cap; the counter is sized once for it.
   localparam int MAX_OUTSTANDING_LIMIT = 15;
   localparam int OUTST_W = $clog2(MAX_OUTSTANDING_LIMIT + 1);

   // Bits needed to hold a count of 0..max_val.
   function automatic int cnt_w(input int max_val);
      if (max_val < 2) return 1;
      return $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/wishbone_arbiter_if.sv
// Bundle of the N master ports and the single slave port of the arbiter.
interface wishbone_arbiter_if #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int NUM_MASTERS = 4
);
   localparam int SEL_WIDTH = DATA_WIDTH / 8;

   logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0] m_adr;
   logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] m_dat_mosi;
   logic [NUM_MASTERS-1:0][SEL_WIDTH-1:0]  m_sel;
   logic [NUM_MASTERS-1:0]                 m_we;
   logic [NUM_MASTERS-1:0]                 m_stb;
   logic [NUM_MASTERS-1:0]                 m_cyc;
   logic [DATA_WIDTH-1:0]                  m_dat_miso;
   logic [NUM_MASTERS-1:0]                 m_stall;
   logic [NUM_MASTERS-1:0]                 m_ack;
   logic [NUM_MASTERS-1:0]                 m_err;
   logic [NUM_MASTERS-1:0]                 m_rty;

   logic [ADDR_WIDTH-1:0]                  s_adr;
   logic [DATA_WIDTH-1:0]                  s_dat_mosi;
   logic [SEL_WIDTH-1:0]                   s_sel;
   logic                                   s_we;
   logic                                   s_stb;
   logic                                   s_cyc;
   logic [DATA_WIDTH-1:0]                  s_dat_miso;
   logic                                   s_stall;
   logic                                   s_ack;
   logic                                   s_err;
   logic                                   s_rty;

   modport arb (
      input  m_adr, m_dat_mosi, m_sel, m_we, m_stb, m_cyc,
      output m_dat_miso, m_stall, m_ack, m_err, m_rty,
      output s_adr, s_dat_mosi, s_sel, s_we, s_stb, s_cyc,
      input  s_dat_miso, s_stall, s_ack, s_err, s_rty
   );

   modport master (
      output m_adr, m_dat_mosi, m_sel, m_we, m_stb, m_cyc,
      input  m_dat_miso, m_stall, m_ack, m_err, m_rty
   );

   modport slave (
      input  s_adr, s_dat_mosi, s_sel, s_we, s_stb, s_cyc,
      output s_dat_miso, s_stall, s_ack, s_err, s_rty
   );

endinterface

// File: rtl/wishbone_rr_picker.sv
// Round-robin selector: first requester at or after ptr, wrapping around.
module wishbone_rr_picker #(
   parameter  int NUM_MASTERS = 4,
   localparam int IDX_W       = $clog2(NUM_MASTERS)
) (
   input  logic [NUM_MASTERS-1:0] req,
   input  logic [IDX_W-1:0]       ptr,
   output logic [NUM_MASTERS-1:0] onehot,
   output logic [IDX_W-1:0]       idx
);

   // Scan from ptr upward and take the first active request.
   always_comb begin : pick
      int  j;
      logic found;
      j      = 0;
      found  = 1'b0;
      onehot = '0;
      idx    = '0;
      for (int k = 0; k < NUM_MASTERS; k++) begin
         j = int'(ptr) + k;
         if (j >= NUM_MASTERS) j = j - NUM_MASTERS;
         if (!found && req[j]) begin
            found     = 1'b1;
            onehot[j] = 1'b1;
            idx       = IDX_W'(j);
         end
      end
   end

endmodule

// File: rtl/wishbone_arbiter.sv
// N-to-1 pipelined Wishbone arbiter with outstanding cap and response timeout.
//
// state   | meaning
// IDLE    | no owner; pick a requester round-robin
// GRANTED | owner routed to slave, responses forwarded
// ABORT   | one dead cycle after a timeout, bus released
module wishbone_arbiter
   import wishbone_pkg::*;
#(
   parameter  int ADDR_WIDTH      = 32,
   parameter  int DATA_WIDTH      = 32,
   parameter  int NUM_MASTERS     = 4,
   parameter  int MAX_OUTSTANDING = 4,
   parameter  int TIMEOUT_CYCLES  = 255,
   localparam int IDX_W           = $clog2(NUM_MASTERS)
) (
   input  logic             clk,
   input  logic             rst,
   wishbone_arbiter_if.arb  bus,
   output logic [IDX_W-1:0] grant
);

   localparam logic [1:0]         IDLE     = ST_IDLE;
   localparam logic [1:0]         GRANTED  = ST_GRANTED;
   localparam logic [1:0]         ABORT    = ST_ABORT;
   localparam int                 TMR_W    = cnt_w(TIMEOUT_CYCLES);
   localparam logic [OUTST_W-1:0] OUT_MAX  = OUTST_W'(MAX_OUTSTANDING);
   localparam logic [TMR_W-1:0]   TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
   localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_MASTERS - 1);

   logic [1:0]             state;
   logic [IDX_W-1:0]       ptr;
   logic [OUTST_W-1:0]     outst;
   logic [TMR_W-1:0]       timer;
   logic                   active;
   logic                   outst_full;
   logic                   resp_any;
   logic                   resp_fwd;
   logic                   timeout_hit;
   logic                   accept;
   logic [IDX_W-1:0]       ptr_after;
   logic [NUM_MASTERS-1:0] pick_onehot;
   logic [IDX_W-1:0]       pick_idx;

   wishbone_rr_picker #(.NUM_MASTERS(NUM_MASTERS)) u_picker (
      .req    (bus.m_cyc),
      .ptr    (ptr),
      .onehot (pick_onehot),
      .idx    (pick_idx)
   );

   // Ownership, response filtering and timeout detection for this cycle.
   always_comb begin
      active      = (state == GRANTED) && bus.m_cyc[grant];
      outst_full  = (outst == OUT_MAX);
      resp_any    = bus.s_ack | bus.s_err | bus.s_rty;
      resp_fwd    = active && (outst != '0) && resp_any;
      // A response in the expiry cycle takes priority over the timeout.
      timeout_hit = (TIMEOUT_CYCLES != 0) && active && (outst != '0) &&
                    !resp_any && (timer == TMR_LAST);
      ptr_after   = (grant == LAST_IDX) ? '0 : grant + 1'b1;
   end

   // Route the owner to the slave and the slave response back to the owner.
   always_comb begin
      bus.s_cyc      = active;
      bus.s_stb      = active && bus.m_stb[grant] && !outst_full;
      bus.s_adr      = active ? bus.m_adr[grant]      : {ADDR_WIDTH{1'b0}};
      bus.s_dat_mosi = active ? bus.m_dat_mosi[grant] : {DATA_WIDTH{1'b0}};
      bus.s_sel      = active ? bus.m_sel[grant]      : {(DATA_WIDTH/8){1'b0}};
      bus.s_we       = active && bus.m_we[grant];
      bus.m_dat_miso = bus.s_dat_miso;
      bus.m_stall    = '1;
      bus.m_ack      = '0;
      bus.m_err      = '0;
      bus.m_rty      = '0;
      if (active) begin
         bus.m_stall[grant] = bus.s_stall | outst_full;
         bus.m_ack[grant]   = resp_fwd & bus.s_ack;
         bus.m_err[grant]   = (resp_fwd & bus.s_err) | timeout_hit;
         bus.m_rty[grant]   = resp_fwd & bus.s_rty;
      end
   end

   assign accept = bus.s_stb && !bus.s_stall;

   // Arbitration state, outstanding count and response timer.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         ptr   <= '0;
         grant <= '0;
         outst <= '0;
         timer <= '0;
      end else begin
         case (state)
            IDLE: begin
               outst <= '0;
               timer <= '0;
               if (|pick_onehot) begin
                  grant <= pick_idx;
                  state <= GRANTED;
               end
            end
            GRANTED: begin
               if (!bus.m_cyc[grant]) begin
                  state <= IDLE;
                  ptr   <= ptr_after;
                  outst <= '0;
                  timer <= '0;
               end else if (timeout_hit) begin
                  state <= ABORT;
                  ptr   <= ptr_after;
                  outst <= '0;
                  timer <= '0;
               end else begin
                  case ({accept, resp_fwd})
                     2'b10:   outst <= outst + 1'b1;
                     2'b01:   outst <= outst - 1'b1;
                     default: outst <= outst;
                  endcase
                  if ((TIMEOUT_CYCLES != 0) && (outst != '0) && !resp_fwd)
                     timer <= timer + 1'b1;
                  else
                     timer <= '0;
               end
            end
            ABORT:   state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wishbone_arbiter.sv
// Directed scenarios followed by random traffic, checked every cycle
// against a behavioural model of the arbitration rules.
module tb_wishbone_arbiter;

   localparam int AW   = 16;
   localparam int DW   = 32;
   localparam int SW   = DW / 8;
   localparam int N    = 4;
   localparam int MAXO = 2;
   localparam int TO   = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] grant;

   always #5 clk = ~clk;

   wishbone_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_MASTERS(N)) bus ();

   wishbone_arbiter #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_MASTERS(N),
      .MAX_OUTSTANDING(MAXO), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .bus   (bus),
      .grant (grant)
   );

   int tests = 0;
   int fails = 0;

   // model: phase 0 = nobody owns, 1 = owned, 2 = post-timeout gap
   int phase, owner, rr, pend, waitc;

   logic [N-1:0] o_stall, o_ack, o_err, o_rty;
   logic         o_scyc, o_sstb;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      phase = 0; owner = 0; rr = 0; pend = 0; waitc = 0;
   endtask

   task automatic check_and_advance();
      logic         act, resp, to, e_sstb;
      logic [N-1:0] e_stall, e_ack, e_err, e_rty;
      if (!rst) model_reset();
      act    = (phase == 1) && bus.m_cyc[owner];
      resp   = act && (pend > 0) && (bus.s_ack || bus.s_err || bus.s_rty);
      to     = act && (pend > 0) && !resp && (waitc + 1 == TO);
      e_sstb = act && bus.m_stb[owner] && (pend < MAXO);
      e_stall = '1; e_ack = '0; e_err = '0; e_rty = '0;
      if (act) begin
         e_stall[owner] = bus.s_stall || (pend == MAXO);
         e_ack[owner]   = resp && bus.s_ack;
         e_err[owner]   = (resp && bus.s_err) || to;
         e_rty[owner]   = resp && bus.s_rty;
      end
      o_stall = bus.m_stall; o_ack = bus.m_ack; o_err = bus.m_err; o_rty = bus.m_rty;
      o_scyc  = bus.s_cyc;   o_sstb = bus.s_stb;
      chk("s_cyc", 64'(bus.s_cyc), 64'(act));
      chk("s_stb", 64'(bus.s_stb), 64'(e_sstb));
      chk("s_adr", 64'(bus.s_adr), act ? 64'(bus.m_adr[owner]) : 64'd0);
      chk("s_dat_mosi", 64'(bus.s_dat_mosi), act ? 64'(bus.m_dat_mosi[owner]) : 64'd0);
      chk("s_sel", 64'(bus.s_sel), act ? 64'(bus.m_sel[owner]) : 64'd0);
      chk("s_we", 64'(bus.s_we), act ? 64'(bus.m_we[owner]) : 64'd0);
      chk("m_stall", 64'(bus.m_stall), 64'(e_stall));
      chk("m_ack", 64'(bus.m_ack), 64'(e_ack));
      chk("m_err", 64'(bus.m_err), 64'(e_err));
      chk("m_rty", 64'(bus.m_rty), 64'(e_rty));
      chk("m_dat_miso", 64'(bus.m_dat_miso), 64'(bus.s_dat_miso));
      if (act) chk("grant", 64'(grant), 64'(owner));
      if (!rst) chk("grant_rst", 64'(grant), 64'd0);
      if (rst) begin
         case (phase)
            0: begin
               pend = 0; waitc = 0;
               for (int k = 0; k < N; k++) begin
                  if (phase == 0 && bus.m_cyc[(rr + k) % N]) begin
                     owner = (rr + k) % N;
                     phase = 1;
                  end
               end
            end
            1: begin
               if (!bus.m_cyc[owner] || to) begin
                  phase = to ? 2 : 0;
                  rr = (owner + 1) % N; pend = 0; waitc = 0;
               end else begin
                  if (pend > 0 && !resp) waitc = waitc + 1; else waitc = 0;
                  pend = pend + ((e_sstb && !bus.s_stall) ? 1 : 0) - (resp ? 1 : 0);
               end
            end
            default: phase = 0;
         endcase
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      check_and_advance();
      @(posedge clk);
      #1;
   endtask

   initial begin
      bus.m_adr = '0; bus.m_dat_mosi = '0; bus.m_sel = '0; bus.m_we = '0;
      bus.m_stb = '0; bus.m_cyc = '0;
      bus.s_dat_miso = '0; bus.s_stall = 1'b0;
      bus.s_ack = 1'b0; bus.s_err = 1'b0; bus.s_rty = 1'b0;
      model_reset();
      rst = 1'b1;
      #1 rst = 1'b0;
      cycle(); cycle();
      rst = 1'b1;

      // Masters 1 and 3 tie after reset; 1 wins, then 3.
      bus.m_adr = {16'h3333, 16'h2222, 16'h1111, 16'h0000};
      bus.m_sel = 16'hF3C1;
      bus.m_cyc = 4'b1010;
      cycle();
      chk("tie_grant1", 64'(grant), 64'd1);
      bus.m_cyc = 4'b1000;
      cycle();
      chk("drop_scyc", 64'(o_scyc), 64'd0);
      cycle();
      chk("next_grant3", 64'(grant), 64'd3);
      bus.m_cyc = 4'b0000;
      cycle();

      // Outstanding cap of 2: third strobe stalls until the first ack.
      bus.m_cyc = 4'b0001;
      cycle();
      bus.m_stb = 4'b0001;
      cycle(); cycle(); cycle();
      chk("cap_stall", 64'(o_stall[0]), 64'd1);
      chk("cap_nostb", 64'(o_sstb), 64'd0);
      bus.s_ack = 1'b1;
      cycle();
      chk("cap_ack", 64'(o_ack), 64'd1);
      bus.s_ack = 1'b0;
      cycle();
      chk("cap_accept_stall", 64'(o_stall[0]), 64'd0);
      chk("cap_accept_stb", 64'(o_sstb), 64'd1);
      bus.m_stb = 4'b0000; bus.s_ack = 1'b1;
      cycle(); cycle();
      bus.s_ack = 1'b0;

      // Unanswered request times out on the 8th idle cycle.
      bus.m_stb = 4'b0001;
      cycle();
      bus.m_stb = 4'b0000;
      for (int i = 1; i < TO; i++) begin
         cycle();
         chk("to_early_err", 64'(o_err), 64'd0);
      end
      cycle();
      chk("to_err", 64'(o_err), 64'd1);
      cycle();
      chk("abort_scyc", 64'(o_scyc), 64'd0);
      chk("abort_stall", 64'(o_stall), 64'hF);
      cycle(); cycle();

      // Ack in the expiry cycle beats the timeout.
      bus.m_stb = 4'b0001;
      cycle();
      bus.m_stb = 4'b0000;
      repeat (TO - 1) cycle();
      bus.s_ack = 1'b1;
      cycle();
      chk("race_ack", 64'(o_ack), 64'd1);
      chk("race_err", 64'(o_err), 64'd0);
      bus.s_ack = 1'b0;
      cycle();
      chk("race_still_granted", 64'(o_scyc), 64'd1);

      // Owner leaves with 2 outstanding; late ack is dropped.
      bus.m_cyc = 4'b0101; bus.m_stb = 4'b0001;
      cycle(); cycle();
      bus.m_stb = 4'b0000; bus.m_cyc = 4'b0100;
      cycle();
      chk("leave_scyc", 64'(o_scyc), 64'd0);
      bus.s_ack = 1'b1;
      cycle();
      chk("late_ack_dropped", 64'(o_ack), 64'd0);
      chk("leave_grant2", 64'(grant), 64'd2);
      cycle();
      chk("zero_out_ack", 64'(o_ack), 64'd0);
      chk("zero_out_stall", 64'(o_stall), 64'hB);
      bus.s_ack = 1'b0;

      // Reset in the middle of a burst from master 2.
      bus.m_stb = 4'b0100; bus.m_we = 4'b0100;
      cycle(); cycle();
      bus.s_ack = 1'b1;
      #2 rst = 1'b0;
      #1;
      chk("rst_scyc", 64'(bus.s_cyc), 64'd0);
      chk("rst_sstb", 64'(bus.s_stb), 64'd0);
      chk("rst_swe", 64'(bus.s_we), 64'd0);
      chk("rst_sadr", 64'(bus.s_adr), 64'd0);
      chk("rst_stall", 64'(bus.m_stall), 64'hF);
      chk("rst_ack", 64'(bus.m_ack), 64'd0);
      chk("rst_grant", 64'(grant), 64'd0);
      cycle();
      rst = 1'b1; bus.s_ack = 1'b0; bus.m_stb = '0; bus.m_we = '0;
      bus.m_cyc = 4'b1111;
      cycle();
      chk("post_rst_grant0", 64'(grant), 64'd0);
      bus.m_cyc = '0;
      cycle();

      // Random traffic against the model.
      for (int n = 0; n < 1500; n++) begin
         int r;
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(15) == 0) bus.m_cyc[i] = ~bus.m_cyc[i];
            bus.m_stb[i]      = 1'($urandom_range(1));
            bus.m_we[i]       = 1'($urandom_range(1));
            bus.m_adr[i]      = AW'($urandom);
            bus.m_dat_mosi[i] = DW'($urandom);
            bus.m_sel[i]      = SW'($urandom);
         end
         bus.s_stall    = ($urandom_range(3) == 0);
         bus.s_dat_miso = DW'($urandom);
         r = $urandom_range(9);
         bus.s_ack = (r == 0);
         bus.s_err = (r == 1);
         bus.s_rty = (r == 2);
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/wishbone_arbiter.md
WISHBONE_ARBITER -- requirements
Module: wishbone_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, address width independent of data width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, multiple of 8; sel width DATA_WIDTH/8.
REQ-003 SHALL have parameter NUM_MASTERS, default 4, range 2..8.
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 4, range 1..15, cap on accepted-but-unanswered requests.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 255, response timeout; 0 disables the timeout.
REQ-006 SHALL have ports: clk  in  1  sole clock; rst  in  1  asynchronous, active-low reset.
REQ-007 SHALL have ports: m_adr/m_dat_mosi/m_sel/m_we/m_stb/m_cyc  in  [NUM_MASTERS] x field width  master requests.
REQ-008 SHALL have ports: m_dat_miso  out  DATA_WIDTH, broadcast to all masters; m_stall/m_ack/m_err/m_rty  out  NUM_MASTERS.
REQ-009 SHALL have ports: s_adr/s_dat_mosi/s_sel/s_we/s_stb/s_cyc  out  slave request; s_dat_miso/s_stall/s_ack/s_err/s_rty  in  slave response.
REQ-010 SHALL have port grant  out  clog2(NUM_MASTERS)  index of the owning master, valid when s_cyc=1.

Function
REQ-011 SHALL implement Wishbone B4 pipelined mode on all ports.
REQ-012 SHALL use states IDLE, GRANTED, ABORT.
REQ-013 IDLE: when any m_cyc=1, SHALL pick a master round-robin, starting at the index after the last owner, and enter GRANTED on the next edge; 1-cycle arbitration latency.
REQ-014 GRANTED: SHALL route the owner's adr/dat_mosi/sel/we combinationally to s_*; s_cyc=1.
REQ-015 s_stb SHALL equal m_stb[owner] AND (outstanding < MAX_OUTSTANDING).
REQ-016 m_stall[owner] SHALL equal s_stall OR (outstanding == MAX_OUTSTANDING); non-owners SHALL see stall=1 and ack/err/rty=0.
REQ-017 Outstanding counter SHALL increment on s_stb&&!s_stall and decrement on s_ack|s_err|s_rty; both in one cycle leaves it unchanged.
REQ-018 A slave response with outstanding==0 SHALL be dropped and not forwarded.
REQ-019 s_ack/s_err/s_rty SHALL pass combinationally to the owner's m_ack/m_err/m_rty.
REQ-020 When m_cyc[owner] falls in GRANTED, s_cyc SHALL fall in the same cycle. The block SHALL clear outstanding, move to IDLE, and drop any later responses.
REQ-021 Timeout timer SHALL count cycles with outstanding>0 and no response, and reset on any response or when outstanding==0.
REQ-022 When the timer reaches TIMEOUT_CYCLES, the block SHALL assert m_err[owner] for 1 cycle, clear outstanding, and enter ABORT.
REQ-023 If a response arrives in the same cycle the timer expires, the response SHALL win and no timeout occurs.
REQ-024 ABORT SHALL hold s_cyc=0 and s_stb=0 and all m_stall=1 for exactly 1 cycle, then return to IDLE.
REQ-025 In IDLE and ABORT, s_adr/s_dat_mosi/s_sel/s_we SHALL be 0.
REQ-026 Round-robin pointer SHALL update to owner+1, mod NUM_MASTERS, on every exit from GRANTED.

Reset
REQ-027 rst=0 SHALL asynchronously force IDLE, pointer=0, grant=0, outstanding=0, timer=0.
REQ-028 During reset: s_cyc=s_stb=s_we=0, s_adr=s_sel=s_dat_mosi=0, m_stall all 1, m_ack/m_err/m_rty all 0.
REQ-029 Reset asserted mid-transaction SHALL abandon it with no response forwarded.
REQ-030 After reset deasserts, the first decision SHALL favour master 0.

Structure
REQ-031 Package wishbone_pkg SHALL hold the state enum and the count-width constants derived via clog2.
REQ-032 Round-robin selection SHALL be one sub-module, wishbone_rr_picker: request vector plus pointer in, one-hot and index out, purely combinational.

Verification
REQ-033 Masters 1 and 3 raise cyc in the same cycle after reset -> grant=1 one cycle later; after master 1 drops cyc, grant=3.
REQ-034 MAX_OUTSTANDING=2, slave never stalls, 3 back-to-back stb -> third stb sees m_stall=1 until the first ack, then is accepted.
REQ-035 TIMEOUT_CYCLES=8, one request never answered -> m_err[owner]=1 on the 8th idle cycle, then 1 ABORT cycle with s_cyc=0.
REQ-036 Ack and timeout expiry in the same cycle -> m_ack=1, m_err=0, state stays GRANTED.
REQ-037 Owner drops cyc with 2 outstanding, slave acks next cycle -> ack dropped, outstanding=0, next requester granted.
REQ-038 rst pulsed low mid-burst -> all outputs at reset values within the same cycle; after release, master 0 wins a 4-way tie.
